// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, instruction
// and width codes, fault causes, and the legality/alignment check used at issue.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        FAULT
    } lsu_state_t;

    localparam logic [3:0] INST_LOAD  = 4'b0001;
    localparam logic [3:0] INST_STORE = 4'b0010;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Illegal width codes take priority over misalignment.
    function automatic logic [1:0] access_fault(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] offset
    );
        logic illegal;
        logic misaligned;
        illegal    = is_store ? (f3 >= 3'b011)
                              : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = ((f3 == F3_H || f3 == F3_HU) && offset[0]) ||
                     ((f3 == F3_W) && (offset != 2'b00));
        if (illegal)
            return FAULT_ILLEGAL;
        else if (misaligned)
            return FAULT_MISALIGN;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: moves the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to the width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // NOTE: o_data gets a default before the case so no path can leave it unassigned (no latch).
    always_comb begin
        o_data = '0;
        case (i_func3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {24'b0, w_shifted[7:0]};
            F3_HU:   o_data = {16'b0, w_shifted[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer: issues one req/gnt/rvalid bus access per
// memory instruction, stalls the core meanwhile and returns extended load data.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        inst_type,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              done,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              fault,
    output logic [1:0]        fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_is_store;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_rd;
    logic [31:0]       r_sd;
    logic [1:0]        r_cause;
    logic [31:0]       r_wb_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_valid_start;
    logic              w_is_store_in;
    logic [1:0]        w_access_cause;
    logic              w_busy;
    logic              w_complete;
    logic              w_timeout;
    logic [31:0]       w_load_data;

    assign w_valid_start  = start && (inst_type == INST_LOAD || inst_type == INST_STORE);
    assign w_is_store_in  = (inst_type == INST_STORE);
    assign w_access_cause = access_fault(w_is_store_in, func3, addr[1:0]);
    assign w_busy         = (r_state == REQ) || (r_state == WAIT);
    assign w_complete     = ((r_state == REQ) && mem_gnt && (r_is_store || mem_rvalid)) ||
                            ((r_state == WAIT) && mem_rvalid);
    // Completion in the final allowed cycle wins over the timeout.
    assign w_timeout      = w_busy && !w_complete && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_load_align u_load_align (
        .i_rdata  (mem_rdata),
        .i_offset (r_addr[1:0]),
        .i_func3  (r_func3),
        .o_data   (w_load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_valid_start)
                    w_next_state = (w_access_cause != FAULT_NONE) ? FAULT : REQ;
            end
            REQ: begin
                if (w_complete)
                    w_next_state = DONE;
                else if (w_timeout)
                    w_next_state = FAULT;
                else if (mem_gnt)
                    w_next_state = WAIT;
            end
            WAIT: begin
                if (w_complete)
                    w_next_state = DONE;
                else if (w_timeout)
                    w_next_state = FAULT;
            end
            DONE:    w_next_state = IDLE;
            FAULT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_store <= 1'b0;
            r_func3    <= '0;
            r_addr     <= '0;
            r_rd       <= '0;
            r_sd       <= '0;
            r_cause    <= FAULT_NONE;
            r_wb_data  <= '0;
            r_cnt      <= '0;
        end else begin
            if ((r_state == IDLE) && w_valid_start) begin
                r_is_store <= w_is_store_in;
                r_func3    <= func3;
                r_addr     <= addr;
                r_rd       <= rd;
                r_sd       <= store_data;
                r_cause    <= w_access_cause;
                r_cnt      <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout)
                r_cause <= FAULT_TIMEOUT;
            if (w_complete && !r_is_store)
                r_wb_data <= w_load_data;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = 4'b0000;
        mem_wdata   = '0;
        done        = 1'b0;
        wb_en       = 1'b0;
        fault       = 1'b0;
        fault_cause = FAULT_NONE;
        stall       = rst && (((r_state == IDLE) && w_valid_start) || w_busy);
        case (r_state)
            REQ: begin
                mem_req  = 1'b1;
                mem_we   = r_is_store;
                mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
                case (r_func3)
                    F3_B, F3_BU: begin
                        mem_be    = 4'b0001 << r_addr[1:0];
                        mem_wdata = {4{r_sd[7:0]}};
                    end
                    F3_H, F3_HU: begin
                        mem_be    = 4'b0011 << r_addr[1:0];
                        mem_wdata = {2{r_sd[15:0]}};
                    end
                    default: begin
                        mem_be    = 4'b1111;
                        mem_wdata = r_sd;
                    end
                endcase
            end
            DONE: begin
                done  = 1'b1;
                wb_en = !r_is_store && (r_rd != 5'd0);
            end
            FAULT: begin
                done        = 1'b1;
                fault       = 1'b1;
                fault_cause = r_cause;
            end
            default: ;
        endcase
    end

    assign wb_rd   = r_rd;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: stores, loads with extension, fault causes,
// bus timeout and asynchronous reset in the middle of an access.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  inst_type = 4'd0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        stall;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    lsu_controller #(
        .TIMEOUT_CYCLES (8),
        .ADDR_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .inst_type   (inst_type),
        .func3       (func3),
        .addr        (addr),
        .store_data  (store_data),
        .rd          (rd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .done        (done),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] t, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] r);
        start      = 1'b1;
        inst_type  = t;
        func3      = f;
        addr       = a;
        store_data = sd;
        rd         = r;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault_cause", 32'(fault_cause), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Invalid inst_type is ignored
        issue(4'b0100, 3'b010, 32'h100, 32'h0, 5'd1);
        chk("bad_type_stall", 32'(stall), 32'd0);
        step();
        start = 1'b0;
        chk("bad_type_req", 32'(mem_req), 32'd0);

        // 1. SW 0xDEADBEEF @0x100, gnt on the first REQ cycle
        issue(4'b0010, 3'b010, 32'h100, 32'hDEADBEEF, 5'd5);
        chk("t1_stall_c0", 32'(stall), 32'd1);
        step();
        start = 1'b0;
        chk("t1_req_c1", 32'(mem_req), 32'd1);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", 32'(mem_be), 32'hF);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_stall_c1", 32'(stall), 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("t1_done_c2", 32'(done), 32'd1);
        chk("t1_wb_en", 32'(wb_en), 32'd0);
        chk("t1_stall_c2", 32'(stall), 32'd0);
        chk("t1_req_c2", 32'(mem_req), 32'd0);
        step();
        chk("t1_done_c3", 32'(done), 32'd0);

        // SB lane placement @0x101
        issue(4'b0010, 3'b000, 32'h101, 32'h12345678, 5'd0);
        step();
        start = 1'b0;
        chk("sb_be", 32'(mem_be), 32'h2);
        chk("sb_wdata", mem_wdata, 32'h78787878);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("sb_done", 32'(done), 32'd1);
        step();

        // 2. LB @0x103, rvalid three cycles after gnt
        issue(4'b0001, 3'b000, 32'h103, 32'h0, 5'd7);
        step();
        start = 1'b0;
        chk("t2_we", 32'(mem_we), 32'd0);
        chk("t2_addr", mem_addr, 32'h100);
        chk("t2_be", 32'(mem_be), 32'h8);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("t2_wait_req", 32'(mem_req), 32'd0);
        chk("t2_wait_stall", 32'(stall), 32'd1);
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80123456;
        step();
        mem_rvalid = 1'b0;
        chk("t2_lb_done", 32'(done), 32'd1);
        chk("t2_lb_wb_en", 32'(wb_en), 32'd1);
        chk("t2_lb_wb_rd", 32'(wb_rd), 32'd7);
        chk("t2_lb_data", wb_data, 32'hFFFFFF80);
        step();
        chk("t2_wb_en_clear", 32'(wb_en), 32'd0);
        chk("t2_data_hold", wb_data, 32'hFFFFFF80);

        // LBU @0x103 with rvalid at first opportunity: done on c3
        issue(4'b0001, 3'b100, 32'h103, 32'h0, 5'd7);
        step();
        start = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        chk("t2_lbu_c2_done", 32'(done), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80123456;
        step();
        mem_rvalid = 1'b0;
        chk("t2_lbu_done", 32'(done), 32'd1);
        chk("t2_lbu_data", wb_data, 32'h00000080);
        step();

        // 3. LW @0x102 -> misaligned
        issue(4'b0001, 3'b010, 32'h102, 32'h0, 5'd3);
        chk("t3_stall_c0", 32'(stall), 32'd1);
        step();
        start = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_cause", 32'(fault_cause), 32'd1);
        chk("t3_req", 32'(mem_req), 32'd0);
        chk("t3_wb_en", 32'(wb_en), 32'd0);
        chk("t3_stall_c1", 32'(stall), 32'd0);
        step();
        chk("t3_fault_clear", 32'(fault), 32'd0);

        // 4. Illegal func3 for load and for store
        issue(4'b0001, 3'b011, 32'h200, 32'h0, 5'd2);
        step();
        start = 1'b0;
        chk("t4_load_cause", 32'(fault_cause), 32'd2);
        step();
        issue(4'b0010, 3'b100, 32'h200, 32'h0, 5'd2);
        step();
        start = 1'b0;
        chk("t4_store_cause", 32'(fault_cause), 32'd2);
        chk("t4_store_req", 32'(mem_req), 32'd0);
        step();

        // 5. gnt never arrives: timeout after 8 REQ cycles
        issue(4'b0010, 3'b010, 32'h300, 32'h11111111, 5'd0);
        step();
        start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req === 1'b1)
                req_cycles++;
            step();
        end
        chk("t5_req_cycles", 32'(req_cycles), 32'd8);
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_cause", 32'(fault_cause), 32'd3);
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        step();
        chk("t5_idle_done", 32'(done), 32'd0);
        chk("t5_idle_stall", 32'(stall), 32'd0);

        // gnt in the last allowed cycle beats the timeout
        issue(4'b0010, 3'b010, 32'h300, 32'h22222222, 5'd0);
        step();
        start = 1'b0;
        repeat (7) step();
        chk("t5_last_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("t5_last_done", 32'(done), 32'd1);
        chk("t5_last_fault", 32'(fault), 32'd0);
        step();

        // 6. Reset asserted while in WAIT
        issue(4'b0001, 3'b010, 32'h400, 32'h0, 5'd9);
        step();
        start   = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("t6_in_wait", 32'(stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("t6_rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        chk("t6_late_done", 32'(done), 32'd0);
        chk("t6_late_data", wb_data, 32'd0);
        issue(4'b0001, 3'b001, 32'h2, 32'h0, 5'd4);
        step();
        start = 1'b0;
        chk("t6_lh_addr", mem_addr, 32'h0);
        chk("t6_lh_be", 32'(mem_be), 32'hC);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80011234;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("t6_lh_done", 32'(done), 32'd1);
        chk("t6_lh_wb_en", 32'(wb_en), 32'd1);
        chk("t6_lh_wb_rd", 32'(wb_rd), 32'd4);
        chk("t6_lh_data", wb_data, 32'hFFFF8001);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
